// File: rtl/quad_encoder_counter.sv
// ---------------------------------------------------------------------------
// QuadEncoderCounter (module quad_encoder_counter)
//
// Conditions one rotary-encoder A/B pin pair and turns it into a WIDTH-bit
// position count that drives a PWM duty-cycle input. The chain is a 2-FF
// synchroniser per pin, then a per-pin stability filter, then an x4
// Gray-code decoder, then an up/down value register.
//
// Optional feature macro: SATURATE_EN
//   defined   -> value clamps at 0 and 2^WIDTH-1. A step at a limit still
//                pulses step and updates dir.
//   undefined -> value wraps modulo 2^WIDTH.
//
// Parameters:
//   WIDTH           bit width of value and of the position counter
//   DEBOUNCE_CYCLES consecutive stable synchronised samples needed (>=1)
//   RESET_VALUE     value loaded on reset and on clear
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset
//   enc_a  in   raw encoder pin A (asynchronous to clk)
//   enc_b  in   raw encoder pin B (asynchronous to clk)
//   clear  in   synchronous clear of value to RESET_VALUE
//   value  out  registered position count
//   step   out  one-cycle pulse on each accepted step
//   dir    out  direction of the last step (1 = up, 0 = down), held
//   err    out  one-cycle pulse when both pins changed at once
// ---------------------------------------------------------------------------
module quad_encoder_counter #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESET_VALUE     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             step,
  output logic             dir,
  output logic             err
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int INIT_W = $clog2(DEBOUNCE_CYCLES + 3) + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEBOUNCE_CYCLES + 2);
  localparam logic [INIT_W-1:0] INIT_ONE  = INIT_W'(1);
  localparam logic [WIDTH-1:0]  RST_VAL   = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0]  VAL_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0]  VAL_MAX   = '1;
  localparam logic [WIDTH-1:0]  VAL_MIN   = '0;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  // Bit 1 carries pin A and bit 0 carries pin B throughout, so {A,B}
  // reads naturally against the Gray sequence 00->10->11->01.
  logic [1:0] pinRaw;
  logic [1:0] meta_q;
  logic [1:0] sync_q;
  logic [1:0] db_q;
  logic [1:0] db_d;
  logic [CNT_W-1:0] dbCnt_q [2];
  logic [CNT_W-1:0] dbCnt_d [2];

  state_t             state_q;
  state_t             state_d;
  logic [INIT_W-1:0]  initCnt_q;
  logic [INIT_W-1:0]  initCnt_d;
  logic [1:0]         prev_q;
  logic [1:0]         prev_d;
  logic [WIDTH-1:0]   value_q;
  logic [WIDTH-1:0]   value_d;
  logic               step_q;
  logic               step_d;
  logic               dir_q;
  logic               dir_d;
  logic               err_q;
  logic               err_d;

  logic               isUp;
  logic               isDown;
  logic [WIDTH-1:0]   valueUp;
  logic [WIDTH-1:0]   valueDown;

  assign pinRaw = {enc_a, enc_b};

  // Two-flop synchroniser per pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= pinRaw;
      sync_q <= meta_q;
    end
  end

  // Stability filter: a new synchronised level must be seen on
  // DEBOUNCE_CYCLES consecutive edges before it is accepted. Any return to
  // the accepted level throws away the partial count.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]    = db_q[i];
      dbCnt_d[i] = dbCnt_q[i];
      if (sync_q[i] == db_q[i]) begin
        dbCnt_d[i] = '0;
      end else if (dbCnt_q[i] == CNT_LAST) begin
        db_d[i]    = sync_q[i];
        dbCnt_d[i] = '0;
      end else begin
        dbCnt_d[i] = dbCnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q <= '0;
      for (int i = 0; i < 2; i++) begin
        dbCnt_q[i] <= '0;
      end
    end else begin
      db_q <= db_d;
      for (int i = 0; i < 2; i++) begin
        dbCnt_q[i] <= dbCnt_d[i];
      end
    end
  end

  // Gray-code transition classification of prev -> current filtered level.
  always_comb begin
    isUp   = 1'b0;
    isDown = 1'b0;
    case ({prev_q, db_q})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: isUp   = 1'b1;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: isDown = 1'b1;
      default: ;
    endcase
  end

  // Candidate next values for each direction; the limits only matter when
  // saturation is built in.
`ifdef SATURATE_EN
  assign valueUp   = (value_q == VAL_MAX) ? value_q : value_q + VAL_ONE;
  assign valueDown = (value_q == VAL_MIN) ? value_q : value_q - VAL_ONE;
`else
  assign valueUp   = value_q + VAL_ONE;
  assign valueDown = value_q - VAL_ONE;
`endif

  // INIT waits long enough for the resting pin level to pass through the
  // synchroniser and filter, tracking it into prev without counting, so the
  // encoder's idle position never shows up as a step after reset.
  always_comb begin
    state_d   = state_q;
    initCnt_d = initCnt_q;
    prev_d    = db_q;
    value_d   = value_q;
    step_d    = 1'b0;
    dir_d     = dir_q;
    err_d     = 1'b0;

    case (state_q)
      INIT: begin
        if (initCnt_q == INIT_LAST) begin
          state_d = RUN;
        end else begin
          initCnt_d = initCnt_q + INIT_ONE;
        end
      end
      RUN: begin
        if ((prev_q ^ db_q) == 2'b11) begin
          err_d = 1'b1;
        end else if (isUp) begin
          step_d  = 1'b1;
          dir_d   = 1'b1;
          value_d = valueUp;
        end else if (isDown) begin
          step_d  = 1'b1;
          dir_d   = 1'b0;
          value_d = valueDown;
        end
      end
      default: state_d = INIT;
    endcase

    // clear overrides only the count; a coincident step still reports.
    if (clear) begin
      value_d = RST_VAL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= INIT;
      initCnt_q <= '0;
      prev_q    <= '0;
      value_q   <= RST_VAL;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      initCnt_q <= initCnt_d;
      prev_q    <= prev_d;
      value_q   <= value_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
    end
  end

  assign value = value_q;
  assign step  = step_q;
  assign dir   = dir_q;
  assign err   = err_q;

endmodule

// File: doc/quad_encoder_counter.md
Name: quad_encoder_counter

Overview:
Conditions one rotary-encoder channel pair (raw A/B pins from io_in) and turns it into a WIDTH-bit position value that feeds a PWM duty-cycle input.
- Processing chain: 2-FF synchroniser, per-pin stability filter, x4 Gray-code decoder, up/down value register.
- Instantiated once per colour channel, upstream of the PWM stage, inside the user-project wrapper.

Parameters:
WIDTH, 8, bit width of value output and counter
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before a pin level is accepted (>=1)
RESET_VALUE, 0, value loaded on reset and on clear

Ports:
clk  input  1  system clock (wb_clk_i in the wrapper)
reset  input  1  asynchronous, active-high reset
enc_a  input  1  raw encoder pin A, asynchronous to clk
enc_b  input  1  raw encoder pin B, asynchronous to clk
clear  input  1  synchronous clear of value to RESET_VALUE
value  output  WIDTH  current position count, registered
step  output  1  one-cycle pulse on each accepted step
dir  output  1  direction of last step: 1 = up, 0 = down; registered, held between steps
err  output  1  one-cycle pulse on an illegal transition (both pins changed)

Behaviour:
- Interface (decided): one clock `clk`; reset `reset` is asynchronous and active-high. All flops clear on reset assertion without waiting for a clock edge.
- Reset values: value=RESET_VALUE, step=0, dir=0, err=0. Sync flops, debounced levels and prev state = 0. FSM = INIT.
- Synchroniser: two flops per pin. Output s_a/s_b.
- Debounce, per pin, counter cnt of width clog2(DEBOUNCE_CYCLES)+1:
  - if s==db: cnt<=0.
  - else if cnt==DEBOUNCE_CYCLES-1: db<=s, cnt<=0.
  - else: cnt<=cnt+1.
  - Any return of s to db before acceptance discards the partial count.
- FSM INIT:
  - Lasts DEBOUNCE_CYCLES+3 edges after reset release.
  - prev<={db_a,db_b} every cycle; no step/err, value unchanged.
  - Exit to RUN on the final INIT edge. This absorbs the resting level of the encoder (e.g. 11) without counting.
- FSM RUN: each cycle compares cur={db_a,db_b} with prev, then prev<=cur.
  - Up sequence: 00->10->11->01->00. Each transition gives step=1, dir=1, value+1.
  - Down sequence: reverse of the up sequence. Each transition gives step=1, dir=0, value-1.
  - Both bits changed: err=1, step=0, value and dir unchanged.
  - No change: step=0, err=0.
- Latency: new pin level sampled first at edge 1 -> db updates at edge DEBOUNCE_CYCLES+2 -> value/step/dir update at edge DEBOUNCE_CYCLES+3.
- Arithmetic: value is modulo 2^WIDTH (wrap) unless SATURATE_EN is defined.
- clear:
  - value<=RESET_VALUE next edge.
  - If clear coincides with a step, clear wins for value; step and dir still reflect the step.
  - clear has no effect on the FSM or filters.
- Reset asserted mid-operation: immediate return to reset values and INIT; any step in flight is lost.
- No combinational path from any input to any output.

Optional Feature:
SATURATE_EN
- Defined: value clamps at 0 and 2^WIDTH-1. A step beyond a limit still pulses step and updates dir, but value holds.
- Undefined: value wraps (2^WIDTH-1 +1 -> 0, 0 -1 -> 2^WIDTH-1).

Test Plan:
(All with WIDTH=8, DEBOUNCE_CYCLES=4, RESET_VALUE=0.)
- Reset and INIT: pins held at 11 through reset and INIT -> value=0, no step/err pulses. Then one up step 11->01 -> value=1, with the step pulse exactly 7 edges after the pin change.
- Full up detent: 00->10->11->01->00, each level held 10 cycles -> 4 step pulses, dir=1, value 0->4. Reverse sequence -> value back to 0, dir=0.
- Bounce: A toggles for 3 cycles then returns, repeated 5 times -> no step, no err, value unchanged.
- Wrap/saturate: preload value to 255 via steps, one more up step -> 0 without macro, 255 with SATURATE_EN (step still pulses). Same check at 0 with a down step -> 255 / 0.
- Illegal: both pins flip 00->11 in the same cycle -> err pulses 1 cycle, step=0, value and dir unchanged.
- clear coincident with a step (value=5) -> value=0, step=1, dir=1 on that edge. Also assert reset mid-sequence -> all outputs zero immediately, INIT repeats.
